// File: rtl/main_control_if.sv
// Instruction-field inputs and registered control outputs of the main decoder.
interface main_control_if;
  logic [5:0] OP;
  logic [5:0] funct;
  logic       jump;
  logic       extop;
  logic       branch;
  logic       memWrite;
  logic       memToReg;
  logic       ALUsrc;
  logic       regWrite;
  logic       regDst;
  logic [2:0] ALUop;
  logic [2:0] ALUctr;
  logic       illegal;

  modport master (
    output OP, funct,
    input  jump, extop, branch, memWrite, memToReg, ALUsrc, regWrite, regDst,
    input  ALUop, ALUctr, illegal
  );

  modport slave (
    input  OP, funct,
    output jump, extop, branch, memWrite, memToReg, ALUsrc, regWrite, regDst,
    output ALUop, ALUctr, illegal
  );
endinterface

// File: rtl/main_control_unit.sv
// Single-cycle MIPS-subset main decoder with ALU control; all outputs registered
// one cycle after OP/funct, cleared by a synchronous active-high reset.
module main_control_unit (
  input  logic           clk,
  input  logic           rst,
  main_control_if.slave  bus
);

  localparam int unsigned OpW  = 6;
  localparam int unsigned AluW = 3;

  localparam logic [OpW-1:0] OpRtype = OpW'(6'b000000);
  localparam logic [OpW-1:0] OpOri   = OpW'(6'b001101);
  localparam logic [OpW-1:0] OpLw    = OpW'(6'b100011);
  localparam logic [OpW-1:0] OpSw    = OpW'(6'b101011);
  localparam logic [OpW-1:0] OpBeq   = OpW'(6'b000100);
  localparam logic [OpW-1:0] OpJ     = OpW'(6'b000010);

  localparam logic [AluW-1:0] CtrAdd = AluW'(3'b000);
  localparam logic [AluW-1:0] CtrSub = AluW'(3'b001);
  localparam logic [AluW-1:0] CtrAnd = AluW'(3'b010);
  localparam logic [AluW-1:0] CtrOr  = AluW'(3'b011);
  localparam logic [AluW-1:0] CtrSlt = AluW'(3'b100);

  typedef struct packed {
    logic            reg_dst;
    logic            alu_src;
    logic            mem_to_reg;
    logic            reg_write;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            extop;
    logic [AluW-1:0] alu_op;
    logic [AluW-1:0] alu_ctr;
    logic            illegal;
  } ctrl_t;

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  // Opcode decode, then ALU control derived from the freshly decoded ALUop.
  always_comb begin
    ctrl_d = '0;
    unique case (bus.OP)
      OpRtype: begin
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = AluW'(3'b100);
      end
      OpOri: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = AluW'(3'b010);
      end
      OpLw: begin
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.extop      = 1'b1;
      end
      OpSw: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.extop     = 1'b1;
      end
      OpBeq: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.extop  = 1'b1;
        ctrl_d.alu_op = AluW'(3'b001);
      end
      OpJ: begin
        ctrl_d.jump = 1'b1;
      end
      default: begin
        ctrl_d.illegal = 1'b1;
      end
    endcase

    unique case (ctrl_d.alu_op)
      AluW'(3'b000): ctrl_d.alu_ctr = CtrAdd;
      AluW'(3'b001): ctrl_d.alu_ctr = CtrSub;
      AluW'(3'b010): ctrl_d.alu_ctr = CtrOr;
      AluW'(3'b011): ctrl_d.alu_ctr = CtrSlt;
      AluW'(3'b100): begin
        unique case (bus.funct[3:0])
          4'b0000: ctrl_d.alu_ctr = CtrAdd;
          4'b0010: ctrl_d.alu_ctr = CtrSub;
          4'b0100: ctrl_d.alu_ctr = CtrAnd;
          4'b0101: ctrl_d.alu_ctr = CtrOr;
          4'b1010: ctrl_d.alu_ctr = CtrSlt;
          default: begin
            // Unsupported R-type function must not write the register file.
            ctrl_d.alu_ctr   = CtrAdd;
            ctrl_d.illegal   = 1'b1;
            ctrl_d.reg_write = 1'b0;
          end
        endcase
      end
      default: ctrl_d.alu_ctr = CtrAdd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign bus.regDst   = ctrl_q.reg_dst;
  assign bus.ALUsrc   = ctrl_q.alu_src;
  assign bus.memToReg = ctrl_q.mem_to_reg;
  assign bus.regWrite = ctrl_q.reg_write;
  assign bus.memWrite = ctrl_q.mem_write;
  assign bus.branch   = ctrl_q.branch;
  assign bus.jump     = ctrl_q.jump;
  assign bus.extop    = ctrl_q.extop;
  assign bus.ALUop    = ctrl_q.alu_op;
  assign bus.ALUctr   = ctrl_q.alu_ctr;
  assign bus.illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_main_control_unit.sv
// Self-checking bench for main_control_unit: directed scenarios plus randomized
// OP/funct/rst streams checked against a table-driven reference model.
module tb_main_control_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  main_control_if bus ();

  main_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference tables: opcode -> {regDst,ALUsrc,memToReg,regWrite,memWrite,branch,jump,extop}, ALUop
  logic [5:0] op_tab  [6] = '{6'b000000, 6'b001101, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
  logic [7:0] ctl_tab [6] = '{8'b10010000, 8'b01010000, 8'b01110001, 8'b01001001, 8'b00000101, 8'b00000010};
  logic [2:0] aop_tab [6] = '{3'b100, 3'b010, 3'b000, 3'b000, 3'b001, 3'b000};
  logic [2:0] amap    [8] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
  logic [3:0] fn_tab  [5] = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b1010};
  logic [2:0] fctr_tab[5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};

  // Expected {ctl[7:0], ALUop, ALUctr, illegal} for inputs captured at one edge.
  function automatic logic [14:0] model(input logic r, input logic [5:0] op, input logic [5:0] fn);
    logic [7:0] ctl;
    logic [2:0] aop;
    logic [2:0] actr;
    logic       ill;
    bit         hit;
    ctl = '0; aop = '0; actr = '0; ill = 1'b1; hit = 1'b0;
    if (r) return '0;
    for (int i = 0; i < 6; i++) begin
      if (op_tab[i] == op) begin
        ctl = ctl_tab[i]; aop = aop_tab[i]; ill = 1'b0;
      end
    end
    if (aop == 3'b100) begin
      for (int i = 0; i < 5; i++) begin
        if (fn_tab[i] == fn[3:0]) begin
          actr = fctr_tab[i]; hit = 1'b1;
        end
      end
      if (!hit) begin
        actr = 3'b000; ill = 1'b1; ctl[4] = 1'b0;
      end
    end else begin
      actr = amap[aop];
    end
    return {ctl, aop, actr, ill};
  endfunction

  function automatic logic [14:0] observed();
    return {bus.regDst, bus.ALUsrc, bus.memToReg, bus.regWrite, bus.memWrite,
            bus.branch, bus.jump, bus.extop, bus.ALUop, bus.ALUctr, bus.illegal};
  endfunction

  // Apply inputs away from the edge, clock once, sample 1 time unit after.
  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn);
    rst = r; bus.OP = op; bus.funct = fn;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] got;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 6'b000000, 6'b100000);
      got = observed();
      checks++;
      if (got !== 15'd0) begin
        failures++;
        $display("FAIL reset_cycle%0d got=%b expected=%b", i, got, 15'd0);
      end
    end
    step(1'b0, 6'b000000, 6'b100000);
    checks++;
    if ({bus.regDst, bus.regWrite, bus.ALUop, bus.illegal} !== 6'b111000) begin
      failures++;
      $display("FAIL reset_release got regDst=%b regWrite=%b ALUop=%b illegal=%b expected 1 1 100 0",
               bus.regDst, bus.regWrite, bus.ALUop, bus.illegal);
    end
  endtask

  task automatic test_opcode_sequence();
    logic [5:0] ops [6] = '{6'b000000, 6'b001101, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    logic [2:0] ctr [6] = '{3'b000, 3'b011, 3'b000, 3'b000, 3'b001, 3'b000};
    logic [14:0] got;
    logic [14:0] exp;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, ops[i], 6'b100000);
      got = observed();
      exp = model(1'b0, ops[i], 6'b100000);
      checks++;
      if (got !== exp || bus.ALUctr !== ctr[i]) begin
        failures++;
        $display("FAIL opseq op=%b got=%b expected=%b ALUctr=%b expected_ctr=%b",
                 ops[i], got, exp, bus.ALUctr, ctr[i]);
      end
    end
  endtask

  task automatic test_rtype_funct();
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] ctr [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 6'b000000, fns[i]);
      checks++;
      if (bus.ALUctr !== ctr[i] || bus.illegal !== 1'b0 || bus.regWrite !== 1'b1) begin
        failures++;
        $display("FAIL rtype funct=%b got ALUctr=%b illegal=%b regWrite=%b expected %b 0 1",
                 fns[i], bus.ALUctr, bus.illegal, bus.regWrite, ctr[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [14:0] got;
    step(1'b0, 6'b000000, 6'b000111);
    checks++;
    if (bus.ALUctr !== 3'b000 || bus.illegal !== 1'b1 || bus.regWrite !== 1'b0 || bus.ALUop !== 3'b100) begin
      failures++;
      $display("FAIL bad_funct got ALUctr=%b illegal=%b regWrite=%b ALUop=%b expected 000 1 0 100",
               bus.ALUctr, bus.illegal, bus.regWrite, bus.ALUop);
    end
    step(1'b0, 6'b111111, 6'b100000);
    got = observed();
    checks++;
    if (got !== 15'b000000000000001) begin
      failures++;
      $display("FAIL bad_op got=%b expected=%b", got, 15'b000000000000001);
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] got;
    step(1'b0, 6'b100011, 6'b000000);
    got = observed();
    checks++;
    if (got !== model(1'b0, 6'b100011, 6'b000000)) begin
      failures++;
      $display("FAIL lw_before_reset got=%b expected=%b", got, model(1'b0, 6'b100011, 6'b000000));
    end
    step(1'b1, 6'b100011, 6'b000000);
    got = observed();
    checks++;
    if (got !== 15'd0) begin
      failures++;
      $display("FAIL lw_reset_override got=%b expected=%b", got, 15'd0);
    end
    step(1'b1, 6'b100011, 6'b000000);
    checks++;
    if (bus.memToReg !== 1'b0 || bus.regWrite !== 1'b0) begin
      failures++;
      $display("FAIL lw_reset_hold got memToReg=%b regWrite=%b expected 0 0", bus.memToReg, bus.regWrite);
    end
  endtask

  task automatic test_funct_ignored();
    logic [5:0] op;
    logic [14:0] got;
    logic [14:0] ref_val;
    for (int i = 1; i < 6; i++) begin
      op = op_tab[i];
      step(1'b0, op, 6'b000000);
      ref_val = observed();
      step(1'b0, op, 6'($urandom));
      got = observed();
      checks++;
      if (got !== ref_val || got !== model(1'b0, op, 6'b000000)) begin
        failures++;
        $display("FAIL funct_ignored op=%b got=%b expected=%b", op, got, model(1'b0, op, 6'b000000));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       r;
    logic [5:0] op;
    logic [5:0] fn;
    logic [14:0] got;
    logic [14:0] exp;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 15) == 0);
      op = ($urandom_range(0, 1) == 0) ? op_tab[$urandom_range(0, 5)] : 6'($urandom);
      fn = ($urandom_range(0, 1) == 0) ? {2'($urandom), fn_tab[$urandom_range(0, 4)]} : 6'($urandom);
      step(r, op, fn);
      got = observed();
      exp = model(r, op, fn);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL b2b i=%0d rst=%b op=%b funct=%b got=%b expected=%b", i, r, op, fn, got, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.OP = '0;
    bus.funct = '0;
    #2;
    test_reset();
    test_opcode_sequence();
    test_rtype_funct();
    test_illegal();
    test_reset_mid();
    test_funct_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_control_unit.md
MAIN_CONTROL_UNIT -- requirements
Module: main_control

Interface
- Parameters: none; all widths fixed.
- REQ-001: clk  input  1  single clock; all outputs update on its rising edge only.
- REQ-002: rst  input  1  reset; synchronous, active-high.
- REQ-003: OP  input  6  instruction opcode field, bits [31:26].
- REQ-004: funct  input  6  instruction function field, bits [5:0]; only bits [3:0] are decoded.
- REQ-005: jump  output  1  select jump target.
- REQ-006: extop  output  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- REQ-007: branch  output  1  conditional branch (beq).
- REQ-008: memWrite  output  1  data-memory write enable.
- REQ-009: memToReg  output  1  register write-back source: 1 = memory, 0 = ALU.
- REQ-010: ALUsrc  output  1  ALU operand B: 1 = extended immediate, 0 = register.
- REQ-011: regWrite  output  1  register-file write enable.
- REQ-012: regDst  output  1  destination register: 1 = rd, 0 = rt.
- REQ-013: ALUop  output  3  ALU operation class.
- REQ-014: ALUctr  output  3  final ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- REQ-015: illegal  output  1  unsupported OP, or unsupported funct under R-type.

Function
- REQ-016: Decode SHALL be combinational from the current OP/funct; every output SHALL be registered, giving exactly 1-cycle latency from input to output.
- REQ-017: Signal order for the opcode table: regDst, ALUsrc, memToReg, regWrite, memWrite, branch, jump, extop; ALUop.
- REQ-018: OP 000000 (R-type) -> 1,0,0,1,0,0,0,0; ALUop 100.
- REQ-019: OP 001101 (ori) -> 0,1,0,1,0,0,0,0; ALUop 010.
- REQ-020: OP 100011 (lw) -> 0,1,1,1,0,0,0,1; ALUop 000.
- REQ-021: OP 101011 (sw) -> 0,1,0,0,1,0,0,1; ALUop 000.
- REQ-022: OP 000100 (beq) -> 0,0,0,0,0,1,0,1; ALUop 001.
- REQ-023: OP 000010 (j) -> 0,0,0,0,0,0,1,0; ALUop 000.
- REQ-024: Any other OP SHALL drive all 1-bit controls 0, ALUop 000, illegal 1; no write enable may assert.
- REQ-025: ALUop to ALUctr mapping: 000 -> 000; 001 -> 001; 010 -> 011; 011 -> 100; 101, 110, 111 -> 000.
- REQ-026: When ALUop is 100, ALUctr SHALL come from funct[3:0]: 0000 -> 000 (add); 0010 -> 001 (sub); 0100 -> 010 (and); 0101 -> 011 (or); 1010 -> 100 (slt).
- REQ-027: Any other funct[3:0] with ALUop 100 SHALL give ALUctr 000 and illegal 1; regWrite SHALL be forced to 0.
- REQ-028: ALUctr SHALL be computed from the ALUop decoded in the same cycle, so registered ALUop and ALUctr always correspond.
- REQ-029: funct SHALL be ignored (no effect on any output) when OP is not 000000.
- REQ-030: Inputs that change every cycle SHALL give back-to-back correct outputs; no internal state beyond the output registers.

Reset
- REQ-031: While rst = 1 at a rising edge, all outputs SHALL be 0 on the next cycle, including ALUop 000, ALUctr 000 and illegal 0.
- REQ-032: Decoding of the inputs present at the first edge with rst = 0 SHALL be visible after that edge; asserting rst mid-sequence SHALL override that cycle's decode.

Verification
- REQ-033: rst = 1 for 2 cycles with OP 000000 -> all outputs 0; release, then after 1 edge regDst = 1, regWrite = 1, ALUop 100.
- REQ-034: Sequence OP 000000, 001101, 100011, 101011, 000100, 000010, one per cycle -> outputs match REQ-018 to REQ-023 each one cycle later; ALUctr follows as 000 (funct 100000), 011, 000, 000, 001, 000.
- REQ-035: OP 000000 with funct 100000, 100010, 100100, 100101, 101010 -> ALUctr 000, 001, 010, 011, 100, with illegal 0 throughout.
- REQ-036: OP 000000 with funct 000111 -> ALUctr 000, illegal 1, regWrite 0. OP 111111 -> all controls 0, illegal 1.
- REQ-037: lw decode in progress, rst = 1 on the next edge -> outputs 0 the following cycle, with no memToReg or regWrite pulse.
